// File: rtl/pipeline_pkg.sv
// Shared encodings and bundle types for the MEM stage and its helpers.
package pipeline_pkg;

    // RV32I load funct3 codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // RV32I store funct3 codes
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    // Writeback result source select
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    typedef enum logic {IDLE, BUSY} mem_state_t;

    // Everything from EX/MEM that the stage needs to finish an op, frozen while BUSY
    typedef struct packed {
        logic        valid;
        logic        we;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc_plus4;
    } mem_bundle_t;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        misalign;
        logic [4:0]  rd;
        logic [1:0]  result_src;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
    } wb_bundle_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores, lane select + extension for loads, alignment check.
module load_store_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] dwdata_o,
    output logic [3:0]  byte_en_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign shifted   = rdata_i >> {addr_lo_i, 3'b000};
    assign byte_lane = shifted[7:0];
    assign half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Decode width from funct3; unknown codes fall back to a full word
    always_comb begin
        dwdata_o    = wdata_i;
        byte_en_o   = 4'b0000;
        load_data_o = rdata_i;
        misalign_o  = 1'b0;
        if (we_i) begin
            case (funct3_i)
                SB: begin
                    dwdata_o  = {4{wdata_i[7:0]}};
                    byte_en_o = 4'b0001 << addr_lo_i;
                end
                SH: begin
                    dwdata_o   = {2{wdata_i[15:0]}};
                    byte_en_o  = 4'b0011 << addr_lo_i;
                    misalign_o = addr_lo_i[0];
                end
                default: begin
                    dwdata_o   = wdata_i;
                    byte_en_o  = 4'b1111;
                    misalign_o = (addr_lo_i != 2'b00);
                end
            endcase
        end else begin
            case (funct3_i)
                LB:  load_data_o = {{24{byte_lane[7]}}, byte_lane};
                LBU: load_data_o = {24'h000000, byte_lane};
                LH: begin
                    load_data_o = {{16{half_lane[15]}}, half_lane};
                    misalign_o  = addr_lo_i[0];
                end
                LHU: begin
                    load_data_o = {16'h0000, half_lane};
                    misalign_o  = addr_lo_i[0];
                end
                default: begin
                    load_data_o = rdata_i;
                    misalign_o  = (addr_lo_i != 2'b00);
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data cache handshake, miss stall FSM, hold register and MEM/WB register.
module mem_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        validM,
    input  logic        regWriteM,
    input  logic        memWriteM,
    input  logic [1:0]  resultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  rdM,
    input  logic [31:0] aluResultM,
    input  logic [31:0] writeDataM,
    input  logic [31:0] pcPlus4M,
    output logic        dReq,
    output logic        dWe,
    output logic [31:0] dAddr,
    output logic [31:0] dWdata,
    output logic [3:0]  dByteEn,
    input  logic [31:0] dRdata,
    input  logic        dReady,
    output logic        stallM,
    output logic [31:0] aluResultW,
    output logic [31:0] readDataW,
    output logic [31:0] pcPlus4W,
    output logic [1:0]  resultSrcW,
    output logic [4:0]  rdW,
    output logic        regWriteW,
    output logic        validW,
    output logic        misalignW
);

    mem_state_t  state_q, state_d;
    mem_bundle_t hold_q, hold_d;
    mem_bundle_t live, sel;
    wb_bundle_t  wb_q, wb_d;

    logic        busy;
    logic        live_mem;
    logic        misalign;
    logic        start;
    logic [31:0] load_data;

    assign live = '{
        valid:      validM,
        we:         memWriteM,
        reg_write:  regWriteM,
        result_src: resultSrcM,
        funct3:     funct3M,
        rd:         rdM,
        addr:       aluResultM,
        wdata:      writeDataM,
        pc_plus4:   pcPlus4M
    };

    assign busy     = (state_q == BUSY);
    // While BUSY the live inputs are ignored; everything comes from the hold register
    assign sel      = busy ? hold_q : live;
    assign live_mem = validM && (memWriteM || (resultSrcM == RES_LOAD));
    assign start    = !busy && live_mem && !misalign;

    load_store_align u_align (
        .funct3_i    (sel.funct3),
        .addr_lo_i   (sel.addr[1:0]),
        .we_i        (sel.we),
        .wdata_i     (sel.wdata),
        .rdata_i     (dRdata),
        .dwdata_o    (dWdata),
        .byte_en_o   (dByteEn),
        .load_data_o (load_data),
        .misalign_o  (misalign)
    );

    assign dWe   = sel.we;
    assign dAddr = {sel.addr[31:2], 2'b00};

    // Request/stall FSM; reset masks dReq/stallM combinationally so they drop at once
    always_comb begin
        state_d = state_q;
        dReq    = 1'b0;
        stallM  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dReq = 1'b1;
                    if (!dReady) begin
                        stallM  = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                dReq = 1'b1;
                if (dReady) begin
                    state_d = IDLE;
                end else begin
                    stallM = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            dReq   = 1'b0;
            stallM = 1'b0;
        end
    end

    // Capture the request every IDLE cycle so BUSY sees the op that started the miss
    assign hold_d = busy ? hold_q : live;

    // MEM/WB next state: a bubble on every stalled edge, otherwise the finished op
    always_comb begin
        wb_d = '0;
        if (!stallM) begin
            wb_d.valid      = sel.valid;
            wb_d.misalign   = !busy && live_mem && misalign;
            wb_d.reg_write  = sel.valid && sel.reg_write && !wb_d.misalign;
            wb_d.rd         = sel.rd;
            wb_d.result_src = sel.result_src;
            wb_d.alu_result = sel.addr;
            wb_d.read_data  = load_data;
            wb_d.pc_plus4   = sel.pc_plus4;
        end
    end

    // State, hold and MEM/WB registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wb_q    <= wb_d;
        end
    end

    assign validW     = wb_q.valid;
    assign regWriteW  = wb_q.reg_write;
    assign misalignW  = wb_q.misalign;
    assign rdW        = wb_q.rd;
    assign resultSrcW = wb_q.result_src;
    assign aluResultW = wb_q.alu_result;
    assign readDataW  = wb_q.read_data;
    assign pcPlus4W   = wb_q.pc_plus4;

endmodule
